// File: rtl/calc_pkg.sv
// Shared calculator definitions so the calc unit and its result FIFO agree on widths.
package calc_pkg;

  localparam int unsigned CALC_RES_W = 16;
  localparam int unsigned CALC_OPD_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

endpackage

// File: rtl/calc_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module calc_fifo_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/calc_result_fifo.sv
// Result buffer between the calc unit and its consumer; valid/stall on both sides,
// plus a running count of results delivered downstream.
module calc_result_fifo
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_RES_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           inC,
  input  logic                       iValid,
  output logic                       iStall,
  output logic [WIDTH-1:0]           outC,
  output logic                       oValid,
  input  logic                       oStall,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNTW-1:0]            resCnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CNTW-1:0] res_cnt_q, res_cnt_d;
  logic            push, pop;

  // Both stall and valid decode only from the level register, so neither
  // handshake side sees a combinational path from the other.
  assign iStall = (level_q == LW'(DEPTH));
  assign oValid = (level_q != '0);
  assign push   = iValid && !iStall;
  assign pop    = oValid && !oStall;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    res_cnt_d = res_cnt_q;
    level_d   = level_q + LW'(push) - LW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      res_cnt_d = res_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      res_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  calc_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (inC),
    .raddr (rd_ptr_q),
    .rdata (outC)
  );

  assign level  = level_q;
  assign resCnt = res_cnt_q;

endmodule
